cache_way_controller: RTL and testbench
=======================================

// Module: cache_way_controller
// PURPOSE
//  Sequencing controller for one 4-way set-associative cache. It holds per-set tags,
//  valid bits, dirty bits and 6-bit pairwise LRU state, and instantiates LRU_BITS.
//  It accepts one request at a time, does tag lookup, picks a victim and runs the
//  write-back/fill handshake with the next memory level. It also drives the way
//  select for the external data array.
// PARAMETERS
//  ADDR_W    32  request/memory address width
//  INDEX_W    6  set index bits (SETS = 2**INDEX_W = 64); addr[OFFSET_W+INDEX_W-1:OFFSET_W]
//  OFFSET_W   4  line offset bits; ignored for lookup, driven 0 on mem_addr
//  TAG_W   ADDR_W-INDEX_W-OFFSET_W (derived localparam, 22) tag = addr[ADDR_W-1:OFFSET_W+INDEX_W]
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst_n      in   1       synchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept (IDLE only)
//  req_addr   in   ADDR_W  request address
//  req_write  in   1       1 = store (marks line dirty), 0 = load
//  resp_valid out  1       one-cycle pulse: request complete
//  resp_hit   out  1       request hit in lookup (valid with resp_valid)
//  resp_way   out  2       way holding the line (valid with resp_valid)
//  mem_req    out  1       memory transfer request, held until mem_ack
//  mem_we     out  1       1 = write-back of victim line, 0 = line fill read
//  mem_addr   out  ADDR_W  line address {tag,index,OFFSET_W'b0}
//  mem_ack    in   1       transfer done; sampled only while mem_req=1
// BEHAVIOUR
//  LRU encoding per set (bit=1 means first way is newer):
//   b5 w0>w1, b4 w0>w2, b3 w0>w3, b2 w1>w2, b1 w1>w3, b0 w2>w3.
//   LRU way: 000xxx->0, 1xx00x->1, x1x1x0->2, xx1x11->3; priority 0..3.
//   MRU update on access to way w: w0 |=111000; w1 &=011111,|=000110;
//   w2 &=101011,|=000001; w3 &=110100.
//  Reset: all valid/dirty/LRU bits 0, FSM=IDLE; req_ready=1 in the first cycle
//   after reset; resp_valid, resp_hit, resp_way, mem_req, mem_we and mem_addr all 0.
//  Reset mid-operation: reset takes priority in any state. An in-flight mem_req drops
//   the next cycle. The pending request is discarded with no response.
//  FSM IDLE -> LOOKUP -> {RESPOND | WB -> FILL -> RESPOND | FILL -> RESPOND} -> IDLE.
//  IDLE: req_ready=1. On req_valid&req_ready, latch addr/write and go to LOOKUP.
//   req_valid is ignored while req_ready=0.
//  LOOKUP (1 cycle): compare the tag against the 4 valid ways.
//   Hit -> RESPOND. Multiple matches: lowest way wins (cannot occur by construction).
//   Miss victim: lowest-index invalid way; if none, the LRU way.
//   Victim valid&dirty -> WB; else -> FILL.
//  WB: mem_req=1, mem_we=1, mem_addr={victim tag,index,0}. Hold until mem_ack, then
//   go to FILL. mem_req stays 1; mem_we/mem_addr change on the next cycle.
//  FILL: mem_req=1, mem_we=0, mem_addr={req tag,index,0}. On mem_ack write the tag,
//   set valid=1, dirty=req_write, and go to RESPOND.
//  RESPOND (1 cycle): resp_valid=1, resp_hit/resp_way from LOOKUP. Apply the MRU
//   update for resp_way. On a write hit set dirty. Then go to IDLE.
//  mem_req/mem_we/mem_addr are stable from assertion until the acked edge.
//   mem_ack may arrive in the first cycle of mem_req.
//  Latency: hit accepted at edge N -> resp_valid high in cycle N+2; next accept at N+3.
//   Miss adds 1 cycle plus ack wait per memory transfer.
// TESTING
//  1 Reset, load 0x0000_1000 -> FILL mem_addr=0x0000_1000 mem_we=0; ack ->
//    resp hit=0 way=0; same load again -> hit=1 way=0, resp_valid 2 cycles after accept.
//  2 Loads 0x0000,0x0400,0x0800,0x0C00 (set 0) -> ways 0,1,2,3; load 0x0000 (hit w0);
//    load 0x1000 -> no WB, fill into way 1 (LRU).
//  3 Store 0x0000 on hit; force eviction of way 0 -> WB mem_we=1 mem_addr=0x0000
//    then FILL of the new address; resp hit=0.
//  4 Hold mem_ack low 5 cycles in FILL -> mem_req/mem_addr stable, req_ready=0,
//    a req_valid pulse in that window is not accepted.
//  5 rst_n low for 1 cycle during WB -> next cycle IDLE, mem_req=0, no resp_valid;
//    prior lines miss.
//  6 Back-to-back hits with req_valid held high -> accepts every 3 cycles; LRU order
//    matches the MRU rules (check victim after hits w3,w2,w1,w0 is w3).

Source files
------------

// File: rtl/cache_way_controller.sv
// Tag/valid/dirty/LRU bookkeeping and request sequencing for one 4-way set-associative cache.
// Handles lookup, victim choice and the write-back/fill handshake with the next memory level.
module cache_way_controller #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [1:0]        resp_way,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack
);

    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS     = 1 << INDEX_W;
    localparam int WAYS     = 4;
    localparam int LRU_BITS = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_RESPOND
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-OFFSET_W-1:0] req_line_q;
    logic                       req_write_q;
    logic                       hit_q;
    logic [1:0]                 way_q;
    logic [TAG_W-1:0]           victim_tag_q;

    logic [TAG_W-1:0]    tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]     valid_mem [SETS];
    logic [WAYS-1:0]     dirty_mem [SETS];
    logic [LRU_BITS-1:0] lru_mem   [SETS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WAYS-1:0]    hit_vec;
    logic               lookup_hit;
    logic [1:0]         hit_way;
    logic [1:0]         victim_way;
    logic [1:0]         lookup_way;
    logic               victim_dirty;

    // Offset bits never participate in lookup or memory addressing.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    assign idx = req_line_q[INDEX_W-1:0];
    assign tag = req_line_q[ADDR_W-OFFSET_W-1:INDEX_W];

    // Bit set means the first way of the pair was used more recently.
    function automatic logic [1:0] lru_victim(input logic [LRU_BITS-1:0] b);
        if (b[5:3] == 3'b000)
            return 2'd0;
        else if (b[5] && !b[2] && !b[1])
            return 2'd1;
        else if (b[4] && b[2] && !b[0])
            return 2'd2;
        else
            return 2'd3;
    endfunction

    function automatic logic [LRU_BITS-1:0] lru_touch(input logic [LRU_BITS-1:0] b,
                                                      input logic [1:0] w);
        case (w)
            2'd0:    return b | 6'b111000;
            2'd1:    return (b & 6'b011111) | 6'b000110;
            2'd2:    return (b & 6'b101011) | 6'b000001;
            default: return b & 6'b110100;
        endcase
    endfunction

    always_comb begin
        hit_vec    = '0;
        hit_way    = 2'd0;
        victim_way = lru_victim(lru_mem[idx]);
        for (int w = 0; w < WAYS; w++)
            hit_vec[w] = valid_mem[idx][w] && (tag_mem[idx][w] == tag);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])
                hit_way = 2'(w);
            if (!valid_mem[idx][w])
                victim_way = 2'(w);
        end
        lookup_hit   = |hit_vec;
        lookup_way   = lookup_hit ? hit_way : victim_way;
        victim_dirty = valid_mem[idx][victim_way] && dirty_mem[idx][victim_way];
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_way   = 2'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lookup_hit)
                    state_nx = S_RESPOND;
                else if (victim_dirty)
                    state_nx = S_WB;
                else
                    state_nx = S_FILL;
            end
            S_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {victim_tag_q, idx, {OFFSET_W{1'b0}}};
                if (mem_ack)
                    state_nx = S_FILL;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag, idx, {OFFSET_W{1'b0}}};
                if (mem_ack)
                    state_nx = S_RESPOND;
            end
            S_RESPOND: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_way   = way_q;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            req_line_q   <= '0;
            req_write_q  <= 1'b0;
            hit_q        <= 1'b0;
            way_q        <= 2'd0;
            victim_tag_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                lru_mem[s]   <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid) begin
                req_line_q  <= req_addr[ADDR_W-1:OFFSET_W];
                req_write_q <= req_write;
            end
            if (state == S_LOOKUP) begin
                hit_q        <= lookup_hit;
                way_q        <= lookup_way;
                victim_tag_q <= tag_mem[idx][lookup_way];
            end
            if (state == S_FILL && mem_ack) begin
                valid_mem[idx][way_q] <= 1'b1;
                dirty_mem[idx][way_q] <= req_write_q;
            end
            if (state == S_RESPOND) begin
                lru_mem[idx] <= lru_touch(lru_mem[idx], way_q);
                if (hit_q && req_write_q)
                    dirty_mem[idx][way_q] <= 1'b1;
            end
        end
    end

    // Tags are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_FILL && mem_ack)
            tag_mem[idx][way_q] <= tag;
    end

endmodule

// File: tb/tb_cache_way_controller.sv
// Scenario bench for cache_way_controller: expected responses and memory transfers are
// queued when requests are driven and checked by response/memory monitors.
module tb_cache_way_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;

    cache_way_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       hit;
        logic [1:0] way;
        bit         chk_lat;
        int         acc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
    } mem_t;

    resp_t exp_resp[$];
    mem_t  exp_mem[$];

    int          ack_delay = 0;
    bit          in_xfer = 0;
    int          wait_cnt = 0;
    logic        cap_we;
    logic [31:0] cap_addr;

    // response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                total++;
                if (exp_resp.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: got hit=%0b way=%0d, required no response", resp_hit, resp_way);
                end else begin
                    r = exp_resp.pop_front();
                    if ({resp_hit, resp_way} !== {r.hit, r.way}) begin
                        bad++;
                        $display("FAIL resp: got hit=%0b way=%0d, required hit=%0b way=%0d",
                                 resp_hit, resp_way, r.hit, r.way);
                    end
                    if (r.chk_lat) begin
                        total++;
                        if (cyc - r.acc !== 1) begin
                            bad++;
                            $display("FAIL hit_latency: got %0d edges after accept, required 1", cyc - r.acc);
                        end
                    end
                end
            end
        end
    end

    // memory responder
    initial begin
        mem_t m;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                in_xfer = 0;
            end
            if (!rst_n || mem_req !== 1'b1) begin
                in_xfer = 0;
                mem_ack = 1'b0;
            end else if (!in_xfer) begin
                in_xfer  = 1;
                wait_cnt = ack_delay;
                cap_we   = mem_we;
                cap_addr = mem_addr;
                total++;
                if (exp_mem.size() == 0) begin
                    bad++;
                    $display("FAIL mem_unexpected: got we=%0b addr=%h, required no transfer", mem_we, mem_addr);
                end else begin
                    m = exp_mem.pop_front();
                    if (mem_we !== m.we || mem_addr !== m.addr) begin
                        bad++;
                        $display("FAIL mem_xfer: got we=%0b addr=%h, required we=%0b addr=%h",
                                 mem_we, mem_addr, m.we, m.addr);
                    end
                end
            end else begin
                total++;
                if (mem_we !== cap_we || mem_addr !== cap_addr) begin
                    bad++;
                    $display("FAIL mem_stable: got we=%0b addr=%h, required we=%0b addr=%h",
                             mem_we, mem_addr, cap_we, cap_addr);
                end
            end
            if (in_xfer) begin
                if (wait_cnt == 0) mem_ack = 1'b1;
                else wait_cnt--;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        ack_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a);
        mem_t m;
        m.we   = we;
        m.addr = a;
        exp_mem.push_back(m);
    endtask

    task automatic send_req(input logic [31:0] a, input logic wr, input logic hit,
                            input logic [1:0] way, input bit lat, input bit want_resp);
        int g = 0;
        resp_t r;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = wr;
        while (req_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (g >= 200) begin
            bad++;
            $display("FAIL accept_timeout: ready=%0b, required 1", req_ready);
        end else if (want_resp) begin
            r.hit = hit;
            r.way = way;
            r.chk_lat = lat;
            r.acc = cyc + 1;
            exp_resp.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_resp.size() != 0 || req_ready !== 1'b1) && g < 300) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (exp_resp.size() != 0) begin
            bad++;
            $display("FAIL drain: pending responses=%0d, required 0", exp_resp.size());
        end
        total++;
        if (exp_mem.size() != 0) begin
            bad++;
            $display("FAIL mem_leftover: pending transfers=%0d, required 0", exp_mem.size());
        end
        exp_resp.delete();
        exp_mem.delete();
    endtask

    task automatic fill_set0();
        for (int i = 0; i < 4; i++) begin
            push_mem(1'b0, 32'(i) << 10);
            send_req(32'(i) << 10, 1'b0, 1'b0, 2'(i), 1'b0, 1'b1);
            drain();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 7;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b required 1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %0b required 0", resp_valid); end
        if (resp_hit !== 1'b0) begin bad++; $display("FAIL rst_resp_hit: got %0b required 0", resp_hit); end
        if (resp_way !== 2'd0) begin bad++; $display("FAIL rst_resp_way: got %0d required 0", resp_way); end
        if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %0b required 0", mem_req); end
        if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %0b required 0", mem_we); end
        if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
    endtask

    task automatic test_miss_then_hit();
        do_reset();
        push_mem(1'b0, 32'h0000_1000);
        send_req(32'h0000_1000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drain();
        send_req(32'h0000_1000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_lru_victim();
        do_reset();
        fill_set0();
        send_req(32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        drain();
        push_mem(1'b0, 32'h0000_1000);
        send_req(32'h0000_1000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_writeback();
        do_reset();
        fill_set0();
        send_req(32'h0000_0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        drain();
        for (int i = 1; i < 4; i++) begin
            send_req(32'(i) << 10, 1'b0, 1'b1, 2'(i), 1'b1, 1'b1);
            drain();
        end
        push_mem(1'b1, 32'h0000_0000);
        push_mem(1'b0, 32'h0000_2000);
        send_req(32'h0000_2000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_ack_stall();
        int g = 0;
        do_reset();
        ack_delay = 5;
        push_mem(1'b0, 32'h0000_2340);
        send_req(32'h0000_2345, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        while (mem_req !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready: got %0b required 0", req_ready);
            end
            req_valid = (i == 1);
            req_addr  = 32'h0000_5000;
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain();
        ack_delay = 0;
        send_req(32'h0000_2345, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        drain();
        push_mem(1'b0, 32'h0000_5000);
        send_req(32'h0000_5000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid_wb();
        int g = 0;
        do_reset();
        push_mem(1'b0, 32'h0000_0000);
        send_req(32'h0000_0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        drain();
        for (int i = 1; i < 4; i++) begin
            push_mem(1'b0, 32'(i) << 10);
            send_req(32'(i) << 10, 1'b0, 1'b0, 2'(i), 1'b0, 1'b1);
            drain();
        end
        ack_delay = 20;
        push_mem(1'b1, 32'h0000_0000);
        send_req(32'h0000_1000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total += 3;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL midrst_mem_req: got %0b required 0", mem_req); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %0b required 1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_resp: got %0b required 0", resp_valid); end
        repeat (5) @(negedge clk);
        ack_delay = 0;
        drain();
        push_mem(1'b0, 32'h0000_0400);
        send_req(32'h0000_0400, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[4];
        int prev_acc = 0;
        int g;
        resp_t r;
        addrs = '{32'h0000_0C00, 32'h0000_0800, 32'h0000_0400, 32'h0000_0000};
        do_reset();
        fill_set0();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = addrs[i];
            g = 0;
            while (req_ready !== 1'b1 && g < 50) begin
                @(negedge clk);
                g++;
            end
            r.hit = 1'b1;
            r.way = 2'(3 - i);
            r.chk_lat = 1'b1;
            r.acc = cyc + 1;
            exp_resp.push_back(r);
            if (i > 0) begin
                total++;
                if (r.acc - prev_acc !== 3) begin
                    bad++;
                    $display("FAIL b2b_spacing: got %0d cycles, required 3", r.acc - prev_acc);
                end
            end
            prev_acc = r.acc;
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain();
        push_mem(1'b0, 32'h0000_1000);
        send_req(32'h0000_1000, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_lru_victim();
        test_writeback();
        test_ack_stall();
        test_reset_mid_wb();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
